// File: rtl/conv2_pkg.sv
// Shared types and geometry defaults for the conv2 feed path.
package conv2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEW_FILT,
    S_STREAM,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int IMG_W_DEF       = 26;
  localparam int IMG_H_DEF       = 26;
  localparam int NUM_FILTERS_DEF = 16;

  function automatic int rdy_per_pass(input int w, input int h);
    return (h - 2) * w;
  endfunction

  function automatic int win_per_pass(input int w, input int h);
    return (h - 2) * (w - 2);
  endfunction

  localparam int RDY_PER_PASS_DEF = rdy_per_pass(IMG_W_DEF, IMG_H_DEF);
  localparam int WIN_PER_PASS_DEF = win_per_pass(IMG_W_DEF, IMG_H_DEF);

endpackage

// File: rtl/conv2_win_tracker.sv
// Tags line-buffer ready strobes with output coordinates and masks the
// first two columns of every row, which never hold a full 3x3 window.
module conv2_win_tracker
  import conv2_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic                     i_rdy,
  output logic                     o_valid,
  output logic [$clog2(IMG_H)-1:0] o_row,
  output logic [$clog2(IMG_W)-1:0] o_col
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_hit;

  assign w_hit = i_en && i_rdy;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_row <= RW'(2);
      r_col <= '0;
    end else if (w_hit) begin
      if (r_col == CW'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Coordinates are forced to zero whenever no window is presented.
  assign o_valid = w_hit && (r_col >= CW'(2));
  assign o_row   = o_valid ? r_row - RW'(2) : '0;
  assign o_col   = o_valid ? r_col - CW'(2) : '0;

endmodule

// File: rtl/conv2_feed_ctrl.sv
// Streams the stored feature map into the conv2 line buffer once per filter
// and presents position-tagged valid windows to the MAC array.
module conv2_feed_ctrl
  import conv2_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int NUM_FILTERS = NUM_FILTERS_DEF,
  parameter int RD_LAT      = 2,
  parameter int ADDR_WIDTH  = $clog2(IMG_W * IMG_H)
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic                           i_hold,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_src_rd_en,
  output logic [ADDR_WIDTH-1:0]          o_src_addr,
  input  logic [DATA_WIDTH-1:0]          i_src_data,
  output logic                           o_lb_new_filter,
  output logic                           o_lb_data_push,
  output logic [DATA_WIDTH-1:0]          o_lb_data_in,
  input  logic                           i_lb_data_rdy,
  output logic                           o_win_valid,
  output logic [$clog2(IMG_H)-1:0]       o_win_row,
  output logic [$clog2(IMG_W)-1:0]       o_win_col,
  output logic [$clog2(NUM_FILTERS):0]   o_filter_idx
);
  localparam int FW  = $clog2(NUM_FILTERS) + 1;
  localparam int DCW = $clog2(RD_LAT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [FW-1:0]         r_filter;
  logic [DCW-1:0]        r_drain;
  logic [RD_LAT-1:0]     r_vld_pipe;
  logic                  w_rd_en, w_trk_en, w_push;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (i_start) w_next = S_NEW_FILT;
      S_NEW_FILT: w_next = S_STREAM;
      S_STREAM:   if (w_rd_en && r_addr == LAST_ADDR) w_next = S_DRAIN;
      S_DRAIN:    if (r_drain == DCW'(RD_LAT)) w_next = S_NEXT;
      S_NEXT:     w_next = (r_filter + FW'(1) == FW'(NUM_FILTERS)) ? S_DONE : S_NEW_FILT;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy          = 1'b0;
    o_done          = 1'b0;
    o_lb_new_filter = 1'b0;
    w_rd_en         = 1'b0;
    w_trk_en        = 1'b0;
    case (r_state)
      S_NEW_FILT: begin o_busy = 1'b1; o_lb_new_filter = 1'b1; end
      S_STREAM:   begin o_busy = 1'b1; w_rd_en = !i_hold; w_trk_en = 1'b1; end
      S_DRAIN:    begin o_busy = 1'b1; w_trk_en = 1'b1; end
      S_NEXT:     o_busy = 1'b1;
      S_DONE:     o_done = 1'b1;
      default:    ;
    endcase
  end

  // Drain holds the FSM until every in-flight read has pushed and its
  // ready strobe has been counted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr     <= '0;
      r_filter   <= '0;
      r_drain    <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe <= RD_LAT'({r_vld_pipe, w_rd_en});
      if (r_state == S_NEW_FILT)
        r_addr <= '0;
      else if (w_rd_en)
        r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);
      if (r_state == S_IDLE && i_start)
        r_filter <= '0;
      else if (r_state == S_NEXT)
        r_filter <= r_filter + FW'(1);
      r_drain <= (r_state == S_DRAIN) ? r_drain + DCW'(1) : '0;
    end
  end

  // The source's read port is already registered, so its data is forwarded
  // straight through in the cycle the push strobe arrives.
  assign w_push         = r_vld_pipe[RD_LAT-1];
  assign o_lb_data_push = w_push;
  assign o_lb_data_in   = w_push ? i_src_data : '0;
  assign o_src_rd_en    = w_rd_en;
  assign o_src_addr     = r_addr;
  assign o_filter_idx   = r_filter;

  conv2_win_tracker #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_trk (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (o_lb_new_filter),
    .i_en    (w_trk_en),
    .i_rdy   (i_lb_data_rdy),
    .o_valid (o_win_valid),
    .o_row   (o_win_row),
    .o_col   (o_win_col)
  );

endmodule

// File: tb/tb_conv2_feed_ctrl.sv
// Bench for conv2_feed_ctrl: default geometry plus a small 8x5 instance.
module tb_conv2_feed_ctrl;
  localparam int DW = 64, W = 26, H = 26, NF = 16, RL = 2;
  localparam int AW = $clog2(W * H), FW = $clog2(NF) + 1;
  localparam int PASS = 1 + W * H + RL + 1 + 1;
  localparam int WPP  = (H - 2) * (W - 2);
  localparam int W2 = 8, H2 = 5, RL2 = 1;
  localparam int AW2 = $clog2(W2 * H2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, errors = 0;

  logic rst = 1'b1, start = 1'b0, hold = 1'b0, start2 = 1'b0, inj_en = 1'b0;
  logic busy, done, rd_en, nf, push, winv, rdy;
  logic [AW-1:0] addr;
  logic [DW-1:0] sdata, ldin;
  logic [4:0] wrow, wcol;
  logic [FW-1:0] fidx;
  logic busy2, done2, rd2, nf2, push2, winv2, rdy2;
  logic [AW2-1:0] addr2;
  logic [DW-1:0] sdata2, ldin2;
  logic [2:0] wrow2, wcol2;
  logic [0:0] fidx2;

  conv2_feed_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .NUM_FILTERS(NF), .RD_LAT(RL)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_hold(hold), .o_busy(busy), .o_done(done),
    .o_src_rd_en(rd_en), .o_src_addr(addr), .i_src_data(sdata), .o_lb_new_filter(nf),
    .o_lb_data_push(push), .o_lb_data_in(ldin), .i_lb_data_rdy(rdy), .o_win_valid(winv),
    .o_win_row(wrow), .o_win_col(wcol), .o_filter_idx(fidx));

  conv2_feed_ctrl #(.DATA_WIDTH(DW), .IMG_W(W2), .IMG_H(H2), .NUM_FILTERS(1), .RD_LAT(RL2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(start2), .i_hold(1'b0), .o_busy(busy2), .o_done(done2),
    .o_src_rd_en(rd2), .o_src_addr(addr2), .i_src_data(sdata2), .o_lb_new_filter(nf2),
    .o_lb_data_push(push2), .o_lb_data_in(ldin2), .i_lb_data_rdy(rdy2), .o_win_valid(winv2),
    .o_win_row(wrow2), .o_win_col(wcol2), .o_filter_idx(fidx2));

  // Source buffers: return the read address after the read latency.
  logic [AW-1:0]  spipe  [RL];
  logic [AW2-1:0] spipe2 [RL2];
  always @(posedge clk) begin
    spipe[0] <= rd_en ? addr : '1;
    for (int i = 1; i < RL; i++) spipe[i] <= spipe[i-1];
    spipe2[0] <= rd2 ? addr2 : '1;
  end
  assign sdata  = DW'(spipe[RL-1]);
  assign sdata2 = DW'(spipe2[RL2-1]);

  // Line buffers: ready one cycle after any push once two rows are stored.
  int lb_cnt = 0, lb_cnt2 = 0;
  logic lb_q = 1'b0, lb_q2 = 1'b0;
  always @(posedge clk) begin
    if (rst || nf) begin lb_cnt <= 0; lb_q <= 1'b0; end
    else begin lb_q <= push && lb_cnt >= 2 * W; if (push) lb_cnt <= lb_cnt + 1; end
    if (rst || nf2) begin lb_cnt2 <= 0; lb_q2 <= 1'b0; end
    else begin lb_q2 <= push2 && lb_cnt2 >= 2 * W2; if (push2) lb_cnt2 <= lb_cnt2 + 1; end
  end
  assign rdy  = lb_q | (inj_en & (nf | !busy));
  assign rdy2 = lb_q2;

  task automatic test_reset;
    rst = 1'b1; inj_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0)  begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    vectors++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b exp 0", rd_en); end
    vectors++; if (nf !== 1'b0)    begin errors++; $display("FAIL rst_new_filter got %b exp 0", nf); end
    vectors++; if (push !== 1'b0)  begin errors++; $display("FAIL rst_push got %b exp 0", push); end
    vectors++; if (winv !== 1'b0)  begin errors++; $display("FAIL rst_win_valid got %b exp 0", winv); end
    vectors++; if (addr !== '0)    begin errors++; $display("FAIL rst_addr got %0d exp 0", addr); end
    vectors++; if (ldin !== '0)    begin errors++; $display("FAIL rst_data got %0h exp 0", ldin); end
    vectors++; if ({wrow, wcol} !== '0) begin errors++; $display("FAIL rst_win_pos got %0d,%0d exp 0,0", wrow, wcol); end
    vectors++; if (fidx !== '0)    begin errors++; $display("FAIL rst_filter got %0d exp 0", fidx); end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      vectors++; if (winv !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL idle_rdy_ignored win_valid %b busy %b exp 0 0", winv, busy); end
    end
    inj_en = 1'b0;
  endtask

  // mode 0: no hold; 1: 5-cycle hold at pixel 100 filter 2; 2: random hold + spurious ready
  task automatic run_full(input int mode, input bit spam);
    int reads = 0, wins = 0, masked = 0, nfp = 0, dones = 0, done_cyc = -1;
    int hold_cnt = 0, hold_idx = 0, hold_wins = 0, exp_done, k, ef, er, ec, a;
    bit hold_used = 0, cur_hold, finished = 0;
    int addr_q[$];
    bit rd_q[$];
    repeat (RL) rd_q.push_back(1'b0);
    inj_en = (mode == 2);
    exp_done = 1 + NF * PASS + ((mode == 1) ? 5 : 0);
    @(negedge clk); start = 1'b1; hold = 1'b0;
    for (int cyc = 1; cyc < 25000; cyc++) begin
      @(negedge clk);
      start = spam && (cyc == 50 || cyc == 5000);
      if (mode == 1 && !hold_used && fidx == 2 && addr == 100) begin
        hold_used = 1; hold_cnt = 5; hold_idx = 0;
      end
      cur_hold = (mode == 2) ? (busy && $urandom_range(0, 3) == 0) : (hold_cnt > 0);
      hold = cur_hold;
      #1;
      if (cyc == 1) begin
        vectors++; if (busy !== 1'b1 || nf !== 1'b1)
          begin errors++; $display("FAIL start_latency busy %b new_filter %b exp 1 1", busy, nf); end
      end
      if (cyc == 2 && mode != 2) begin
        vectors++; if (rd_en !== 1'b1 || addr !== '0)
          begin errors++; $display("FAIL first_read rd_en %b addr %0d exp 1 0", rd_en, addr); end
      end
      if (done_cyc < 0 && done !== 1'b1) begin
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL busy cyc %0d got %b exp 1", cyc, busy); end
      end
      if (cur_hold) begin
        vectors++; if (rd_en !== 1'b0) begin errors++; $display("FAIL hold_read cyc %0d got %b exp 0", cyc, rd_en); end
      end
      if (mode == 1 && cur_hold) begin
        vectors++; if (addr !== AW'(100)) begin errors++; $display("FAIL hold_addr got %0d exp 100", addr); end
        if (hold_idx > 0 && winv === 1'b1) hold_wins++;
        hold_idx++; hold_cnt--;
      end
      if (rd_en === 1'b1) begin
        vectors++; if (addr !== AW'(reads % (W * H)) || fidx !== FW'(reads / (W * H)))
          begin errors++; $display("FAIL read_seq #%0d got addr %0d f%0d exp %0d f%0d", reads, addr, fidx, reads % (W * H), reads / (W * H)); end
        addr_q.push_back(int'(addr)); reads++;
      end
      vectors++; if (push !== logic'(rd_q[0]))
        begin errors++; $display("FAIL push_delay cyc %0d got %b exp %b", cyc, push, rd_q[0]); end
      void'(rd_q.pop_front()); rd_q.push_back(rd_en === 1'b1);
      vectors++;
      if (push === 1'b1) begin
        if (addr_q.size() == 0) begin errors++; $display("FAIL push_no_read cyc %0d", cyc); end
        else begin
          a = addr_q.pop_front();
          if (ldin !== DW'(a)) begin errors++; $display("FAIL push_data got %0d exp %0d", ldin, a); end
        end
      end else if (ldin !== '0) begin errors++; $display("FAIL idle_data got %0h exp 0", ldin); end
      if (winv === 1'b1) begin
        k = wins; ef = k / WPP; er = (k % WPP) / (W - 2); ec = k % (W - 2);
        vectors++; if (fidx !== FW'(ef) || wrow !== 5'(er) || wcol !== 5'(ec))
          begin errors++; $display("FAIL window #%0d got f%0d (%0d,%0d) exp f%0d (%0d,%0d)", k, fidx, wrow, wcol, ef, er, ec); end
        wins++;
      end
      if (lb_q === 1'b1 && winv === 1'b0) masked++;
      if (rdy === 1'b1 && lb_q === 1'b0) begin
        vectors++; if (winv !== 1'b0) begin errors++; $display("FAIL spurious_rdy got win_valid %b exp 0", winv); end
      end
      if (nf === 1'b1) nfp++;
      if (done === 1'b1) begin
        dones++; if (done_cyc < 0) done_cyc = cyc;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy got %b exp 0", busy); end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) begin finished = 1; break; end
    end
    hold = 1'b0; start = 1'b0; inj_en = 1'b0;
    vectors++; if (!finished) begin errors++; $display("FAIL timeout mode %0d no done seen", mode); end
    vectors++; if (dones != 1) begin errors++; $display("FAIL done_count got %0d exp 1", dones); end
    vectors++; if (nfp != NF) begin errors++; $display("FAIL new_filter_count got %0d exp %0d", nfp, NF); end
    vectors++; if (reads != NF * W * H) begin errors++; $display("FAIL read_count got %0d exp %0d", reads, NF * W * H); end
    vectors++; if (wins != NF * WPP) begin errors++; $display("FAIL window_count got %0d exp %0d", wins, NF * WPP); end
    vectors++; if (masked != NF * 2 * (H - 2)) begin errors++; $display("FAIL masked_count got %0d exp %0d", masked, NF * 2 * (H - 2)); end
    if (mode != 2) begin
      vectors++; if (done_cyc != exp_done) begin errors++; $display("FAIL done_time got %0d exp %0d", done_cyc, exp_done); end
    end
    if (mode == 1) begin
      vectors++; if (!hold_used || hold_wins != RL)
        begin errors++; $display("FAIL hold_windows got %0d exp %0d (hold seen %0d)", hold_wins, RL, hold_used); end
    end
  endtask

  task automatic test_reset_midrun;
    bit hit = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk); #1;
      if (fidx == 3 && addr == 300) begin hit = 1; break; end
    end
    vectors++; if (!hit) begin errors++; $display("FAIL reach_reset_point got none exp f3 addr300"); end
    rst = 1'b1;
    @(negedge clk); #1;
    vectors++; if ({busy, done, rd_en, nf, push, winv, addr, ldin, wrow, wcol, fidx} !== '0)
      begin errors++; $display("FAIL reset_mid got busy%b rd%b push%b addr%0d f%0d exp all 0", busy, rd_en, push, addr, fidx); end
    rst = 1'b0;
    run_full(0, 1'b1);
  endtask

  task automatic test_small_cfg;
    int reads = 0, wins = 0, done_cyc = -1, lr = -1, lc = -1, k, a;
    int q[$];
    @(negedge clk); start2 = 1'b1;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk); start2 = 1'b0; #1;
      if (rd2 === 1'b1) begin
        vectors++; if (addr2 !== AW2'(reads)) begin errors++; $display("FAIL small_addr got %0d exp %0d", addr2, reads); end
        q.push_back(int'(addr2)); reads++;
      end
      if (push2 === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin errors++; $display("FAIL small_push_no_read cyc %0d", cyc); end
        else begin
          a = q.pop_front();
          if (ldin2 !== DW'(a)) begin errors++; $display("FAIL small_data got %0d exp %0d", ldin2, a); end
        end
      end
      if (winv2 === 1'b1) begin
        k = wins;
        vectors++; if (wrow2 !== 3'(k / (W2 - 2)) || wcol2 !== 3'(k % (W2 - 2)) || fidx2 !== 1'b0)
          begin errors++; $display("FAIL small_window #%0d got (%0d,%0d) exp (%0d,%0d)", k, wrow2, wcol2, k / (W2 - 2), k % (W2 - 2)); end
        lr = int'(wrow2); lc = int'(wcol2); wins++;
      end
      if (done2 === 1'b1) begin done_cyc = cyc; break; end
    end
    vectors++; if (reads != W2 * H2) begin errors++; $display("FAIL small_reads got %0d exp %0d", reads, W2 * H2); end
    vectors++; if (wins != 18) begin errors++; $display("FAIL small_windows got %0d exp 18", wins); end
    vectors++; if (lr != 2 || lc != 5) begin errors++; $display("FAIL small_last got (%0d,%0d) exp (2,5)", lr, lc); end
    vectors++; if (done_cyc != 1 + (1 + 40 + 2 + 1)) begin errors++; $display("FAIL small_done_time got %0d exp 45", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_small_cfg();
    run_full(0, 1'b0);
    run_full(1, 1'b0);
    run_full(2, 1'b0);
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
